// File: rtl/sound_arbiter_if.sv
// Sound-event bus between the game logic (master) and the tone arbiter (slave).
interface sound_arbiter_if;
    logic       tick;
    logic [3:0] req;
    logic       soundOn;
    logic [1:0] toneSel;
    logic       busy;
    logic [3:0] pending;

    modport master (
        output tick, req,
        input  soundOn, toneSel, busy, pending
    );

    modport slave (
        input  tick, req,
        output soundOn, toneSel, busy, pending
    );
endinterface

// File: rtl/sound_arbiter.sv
// Priority arbiter that shares one tone generator among four sound events,
// playing each granted tone for PLAY_TICKS ticks followed by GAP_TICKS of silence.
module sound_arbiter #(
    parameter int PLAY_TICKS = 10,
    parameter int GAP_TICKS  = 2
) (
    input  logic           clk,
    input  logic           resetN,
    sound_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [3:0] PLAY_LAST = 4'(PLAY_TICKS - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_TICKS - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] pend_q, pend_d;
    logic [1:0] tone_q, tone_d;
    logic       sound_q, sound_d;

    logic [3:0] above_tone;
    logic       preempt;
    logic       top_valid;
    logic [1:0] top_idx;
    logic       grant;
    logic [3:0] clr;

    // A pending request outranks the current tone only if its index is strictly higher.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_above
            assign above_tone[gi] = pend_q[gi] && (tone_q < 2'(gi));
        end
    endgenerate

    assign preempt   = |above_tone;
    assign top_valid = |pend_q;

    always_comb begin
        top_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pend_q[i]) begin
                top_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tone_d  = tone_q;
        grant   = 1'b0;
        clr     = 4'b0000;

        case (state_q)
            IDLE: begin
                if (top_valid) begin
                    grant   = 1'b1;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // Preemption is checked first so it overrides a coincident expiry.
                if (preempt) begin
                    grant = 1'b1;
                end else if (bus.tick) begin
                    if (cnt_q == PLAY_LAST) begin
                        state_d = GAP;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            GAP: begin
                if (bus.tick) begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (grant) begin
            tone_d = top_idx;
            cnt_d  = 4'd0;
            clr    = 4'b0001 << top_idx;
        end

        // A new request on the cycle its bit is granted survives the clear.
        pend_d  = (pend_q & ~clr) | bus.req;
        sound_d = (state_d == PLAY);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 4'd0;
            tone_q  <= 2'd0;
            sound_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            tone_q  <= tone_d;
            sound_q <= sound_d;
        end
    end

    assign bus.soundOn = sound_q;
    assign bus.toneSel = tone_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.pending = pend_q;

endmodule
